dma_spi_engine: RTL and testbench
=================================

# dma_spi_engine

Byte-level SPI master that serves as the SPI device behind the DMA controller and the Z80 SPI data port. It accepts one-byte exchange requests from the DMA (`spi_req`/`spi_wrdata`) or from the CPU port, shifts the byte out in SPI mode 0 (MSB first) and captures the simultaneously received byte. It returns the received byte to the DMA with a one-cycle `spi_stb`, or holds it for CPU readback. Chip select is driven by a separate port register and is outside this block.

## Interface
- `DIV_W`, 4 — width of the SCK half-period divider.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `div`  in  DIV_W  SCK half-period minus 1, in `clk` cycles; sampled only when a byte starts.
- `cpu_wr`  in  1  one-cycle strobe: CPU wrote the SPI data port.
- `cpu_din`  in  8  CPU write data, valid with `cpu_wr`.
- `cpu_rd`  in  1  one-cycle strobe: CPU read the data port; launches an exchange with byte 0xFF.
- `cpu_dout`  out  8  last byte received by a CPU-originated exchange.
- `busy`  out  1  high while a byte is in flight or a CPU request is pending.
- `spi_req`  in  1  DMA requests a byte exchange; level, held until served.
- `spi_wrdata`  in  8  DMA transmit byte; the DMA sends 0xFF on read cycles.
- `spi_rddata`  out  8  received byte for the DMA; valid while `spi_stb` is high and held afterwards.
- `spi_stb`  out  1  one-cycle pulse: DMA byte complete.
- `sck`  out  1  SPI clock; idles low.
- `mosi`  out  1  SPI data out.
- `miso`  in  1  SPI data in; already synchronised.

## Operation
- **State machine:** IDLE, SHIFT, DONE.
- **IDLE request priority:**
  - `spi_req` is served first, with source DMA.
  - Otherwise a pending CPU request is served, with source CPU.
  - Otherwise nothing starts.
- **On start:**
  - `tx` ← byte; `div_r` ← `div`; `hctr` ← `div`; `edge` counter ← 0; `sck` ← 0.
  - `mosi` ← `tx[7]`.
  - Source flag stored; state goes to SHIFT.
- **CPU pending slot (one deep):**
  - `cpu_wr` loads the slot with `cpu_din`; `cpu_rd` loads it with 0xFF.
  - The slot can be written in any state. A later strobe overwrites an unserved one (last wins).
  - The slot is cleared on the cycle it is consumed.
  - `cpu_wr` and `cpu_rd` in the same cycle: `cpu_wr` wins.
- **SHIFT:**
  - Each cycle: if `hctr` ≠ 0, decrement. If `hctr` = 0, reload `div_r`, toggle `sck` and increment the 4-bit edge counter.
  - Rising edge (even edge count before the increment): shift `miso` into `rx` LSB-first, so that after 8 bits `rx[7]` is the first bit received.
  - Falling edge: shift `tx` left and set `mosi` ← new `tx[7]`.
  - After the 16th toggle (falling edge, `sck` back to 0), go to DONE. `mosi` keeps its last value.
- **DONE (one cycle):**
  - Source DMA: `spi_rddata` ← `rx` and `spi_stb` = 1.
  - Source CPU: `cpu_dout` ← `rx`.
  - Next state is IDLE.
- **`busy`** = (state ≠ IDLE) or pending slot valid.
- A DMA request that rises during a CPU byte waits for IDLE. The DMA is never pre-empted mid-byte, and the CPU byte is never dropped.
- After `spi_stb`, the DMA's `spi_req` is re-sampled in IDLE on the next cycle. Back-to-back DMA bytes therefore have exactly one IDLE cycle between them.

## Timing
- **Reset values:** `sck` = 0, `mosi` = 1, `spi_stb` = 0, `spi_rddata` = 0xFF, `cpu_dout` = 0xFF, `busy` = 0. Pending slot cleared, state IDLE.
- **Reset mid-byte:** the transfer is aborted with no strobe, and `sck` is low on the cycle after `rst`.
- **Latency:** the request is accepted on edge E0 (state IDLE). SHIFT occupies 16·(`div_r`+1) cycles, then DONE.
  - `spi_stb` is high in cycle E0 + 16·(`div_r`+1) + 1.
  - Next accept is no earlier than E0 + 16·(`div_r`+1) + 2.
- **Per-byte period:** with continuous DMA requests, one byte every 16·(`div`+1) + 2 cycles.
- **SCK waveform:** high and low half-periods are each exactly `div_r`+1 cycles. `div` changes mid-byte have no effect.
- **Sampling:** `miso` is sampled on the `clk` edge that drives `sck` high. `mosi` changes only on the `clk` edge that drives `sck` low, or at start.

## Test plan
- **DMA byte:** `div` = 0, `spi_req` = 1 with `spi_wrdata` = 0xA5, slave returns 0x3C.
  - `mosi` bits are 1,0,1,0,0,1,0,1 on rising edges.
  - `spi_stb` is high 17 cycles after accept, with `spi_rddata` = 0x3C.
  - `cpu_dout` stays 0xFF.
- **Divider:** `div` = 3, 2 bytes via `spi_req`.
  - Each `sck` half-period is 4 cycles.
  - The two `spi_stb` pulses are 66 cycles apart.
  - Changing `div` to 0 mid-byte does not alter that byte.
- **CPU exchange:** `cpu_rd` pulse with slave returning 0x81.
  - `mosi` stays 1 for all 8 bits.
  - `cpu_dout` = 0x81 after DONE; `spi_stb` never pulses.
  - `busy` is high from the strobe until IDLE.
- **Arbitration:**
  - `cpu_wr` 0x11 and `spi_req` arrive in the same cycle: the DMA byte goes first, then 0x11 is sent with one IDLE cycle between.
  - A second `cpu_wr` 0x22 issued before service replaces 0x11.
- **Reset mid-byte:** `rst` is asserted at `sck` edge 5.
  - Next cycle: `sck` = 0, `mosi` = 1, `busy` = 0.
  - No `spi_stb`; `spi_rddata` = 0xFF.
  - A new request then completes normally.

Source files
------------

// File: rtl/dma_spi_engine.sv
// Byte-wide SPI mode-0 master shared by the DMA channel and the CPU data port.
// DMA requests win arbitration in IDLE; CPU bytes wait in a one-deep pending slot.
module dma_spi_engine #(
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div,
  input  logic             cpu_wr,
  input  logic [7:0]       cpu_din,
  input  logic             cpu_rd,
  output logic [7:0]       cpu_dout,
  output logic             busy,
  input  logic             spi_req,
  input  logic [7:0]       spi_wrdata,
  output logic [7:0]       spi_rddata,
  output logic             spi_stb,
  output logic             sck,
  output logic             mosi,
  input  logic             miso
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [7:0]       tx;
  logic [7:0]       rx;
  logic [DIV_W-1:0] div_r;
  logic [DIV_W-1:0] hctr;
  logic [3:0]       ecnt;
  logic             src_dma;
  logic             pend_v;
  logic [7:0]       pend_d;
  logic             start_dma;
  logic             start_cpu;

  assign start_dma = (state == IDLE) && spi_req;
  assign start_cpu = (state == IDLE) && !spi_req && pend_v;
  assign busy      = (state != IDLE) || pend_v;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tx         <= 8'hFF;
      rx         <= 8'h00;
      div_r      <= '0;
      hctr       <= '0;
      ecnt       <= 4'd0;
      src_dma    <= 1'b0;
      pend_v     <= 1'b0;
      pend_d     <= 8'hFF;
      sck        <= 1'b0;
      mosi       <= 1'b1;
      spi_stb    <= 1'b0;
      spi_rddata <= 8'hFF;
      cpu_dout   <= 8'hFF;
    end else begin
      spi_stb <= 1'b0;

      // A strobe landing on the consume cycle refills the slot (last wins).
      if (cpu_wr) begin
        pend_v <= 1'b1;
        pend_d <= cpu_din;
      end else if (cpu_rd) begin
        pend_v <= 1'b1;
        pend_d <= 8'hFF;
      end else if (start_cpu) begin
        pend_v <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start_dma || start_cpu) begin
            tx      <= start_dma ? spi_wrdata : pend_d;
            mosi    <= start_dma ? spi_wrdata[7] : pend_d[7];
            div_r   <= div;
            hctr    <= div;
            ecnt    <= 4'd0;
            sck     <= 1'b0;
            src_dma <= start_dma;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (hctr != '0) begin
            hctr <= hctr - 1'b1;
          end else begin
            hctr <= div_r;
            sck  <= ~sck;
            ecnt <= ecnt + 4'd1;
            if (!ecnt[0]) begin
              rx <= {rx[6:0], miso};
            end else if (ecnt != 4'd15) begin
              tx   <= {tx[6:0], 1'b0};
              mosi <= tx[6];
            end
            // Last falling edge leaves mosi untouched and ends the byte.
            if (ecnt == 4'd15) state <= DONE;
          end
        end
        DONE: begin
          if (src_dma) begin
            spi_rddata <= rx;
            spi_stb    <= 1'b1;
          end else begin
            cpu_dout <= rx;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dma_spi_engine.sv
// Scoreboard bench for dma_spi_engine: stimulus queues expected bytes, a
// negedge monitor acts as the SPI slave and checks every completed byte.
module tb_dma_spi_engine;
  localparam int DIV_W = 4;

  typedef struct {
    logic       dma;
    logic [7:0] tx;
    logic [7:0] rx;
    int         hp;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [DIV_W-1:0] div = '0;
  logic             cpu_wr = 1'b0;
  logic [7:0]       cpu_din = 8'h00;
  logic             cpu_rd = 1'b0;
  logic [7:0]       cpu_dout;
  logic             busy;
  logic             spi_req = 1'b0;
  logic [7:0]       spi_wrdata = 8'h00;
  logic [7:0]       spi_rddata;
  logic             spi_stb;
  logic             sck;
  logic             mosi;
  logic             miso = 1'b1;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t exp_q[$];

  dma_spi_engine #(.DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst), .div(div),
    .cpu_wr(cpu_wr), .cpu_din(cpu_din), .cpu_rd(cpu_rd),
    .cpu_dout(cpu_dout), .busy(busy),
    .spi_req(spi_req), .spi_wrdata(spi_wrdata),
    .spi_rddata(spi_rddata), .spi_stb(spi_stb),
    .sck(sck), .mosi(mosi), .miso(miso)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_stb(output int at);
    at = -1;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (spi_stb) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) chk("stb_timeout", 0, 1);
  endtask

  // Monitor / SPI slave: samples away from the active edge.
  initial begin : monitor
    logic       prev_sck;
    logic       pend_chk;
    logic [7:0] tx_cap;
    int         rises, falls, len;
    exp_t       e;
    prev_sck = 1'b0; pend_chk = 1'b0; tx_cap = 8'h00;
    rises = 0; falls = 0; len = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_sck = 1'b0; pend_chk = 1'b0; rises = 0; falls = 0; len = 0;
        miso = 1'b1;
        continue;
      end
      if (pend_chk) begin
        pend_chk = 1'b0;
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("mosi_byte", tx_cap, e.tx);
          if (e.dma) begin
            chk("dma_stb", spi_stb, 1);
            chk("dma_rddata", spi_rddata, e.rx);
          end else begin
            chk("cpu_no_stb", spi_stb, 0);
            chk("cpu_dout", cpu_dout, e.rx);
          end
        end
      end else if (spi_stb) begin
        chk("stray_stb", 1, 0);
      end
      if (sck !== prev_sck) begin
        if ((rises + falls) > 0 && exp_q.size() > 0) chk("sck_half_period", len, exp_q[0].hp);
        len = 1;
        if (sck) begin
          tx_cap = {tx_cap[6:0], mosi};
          rises++;
        end else begin
          falls++;
          if (falls == 8) begin
            pend_chk = 1'b1;
            rises = 0;
            falls = 0;
          end
        end
      end else begin
        len++;
      end
      prev_sck = sck;
      miso = (exp_q.size() > 0 && rises < 8) ? exp_q[0].rx[7-rises] : 1'b1;
    end
  end

  initial begin : stim
    int n, t1, t2;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_sck", sck, 0);
    chk("rst_mosi", mosi, 1);
    chk("rst_stb", spi_stb, 0);
    chk("rst_rddata", spi_rddata, 8'hFF);
    chk("rst_cpu_dout", cpu_dout, 8'hFF);
    chk("rst_busy", busy, 0);

    // Single DMA byte, div=0.
    div = 4'd0;
    exp_q.push_back('{dma: 1'b1, tx: 8'hA5, rx: 8'h3C, hp: 1});
    spi_wrdata = 8'hA5; spi_req = 1'b1;
    tick();
    spi_req = 1'b0;
    chk("dma_busy", busy, 1);
    n = 0;
    while (!spi_stb && n < 200) begin tick(); n++; end
    chk("dma_latency", n, 17);
    chk("dma_cpu_dout_kept", cpu_dout, 8'hFF);
    repeat (4) tick();

    // Two back-to-back DMA bytes at div=3; div changes mid-second-byte.
    div = 4'd3;
    exp_q.push_back('{dma: 1'b1, tx: 8'h96, rx: 8'h5B, hp: 4});
    exp_q.push_back('{dma: 1'b1, tx: 8'hC3, rx: 8'h24, hp: 4});
    spi_wrdata = 8'h96; spi_req = 1'b1;
    wait_stb(t1);
    spi_wrdata = 8'hC3;
    tick();
    spi_req = 1'b0;
    repeat (10) tick();
    div = 4'd0;
    wait_stb(t2);
    chk("dma_period", t2 - t1, 66);
    repeat (4) tick();

    // CPU read exchange.
    exp_q.push_back('{dma: 1'b0, tx: 8'hFF, rx: 8'h81, hp: 1});
    cpu_rd = 1'b1;
    tick();
    cpu_rd = 1'b0;
    n = 0;
    while (busy && n < 200) begin n++; tick(); end
    chk("cpu_busy_span", n, 18);
    tick();
    chk("cpu_dout_final", cpu_dout, 8'h81);
    repeat (3) tick();

    // Arbitration: DMA first, CPU slot overwritten 0x11 -> 0x22.
    exp_q.push_back('{dma: 1'b1, tx: 8'h3D, rx: 8'hE7, hp: 1});
    exp_q.push_back('{dma: 1'b0, tx: 8'h22, rx: 8'h42, hp: 1});
    cpu_din = 8'h11; cpu_wr = 1'b1;
    spi_wrdata = 8'h3D; spi_req = 1'b1;
    tick();
    cpu_wr = 1'b0; spi_req = 1'b0;
    repeat (3) tick();
    cpu_din = 8'h22; cpu_wr = 1'b1;
    tick();
    cpu_wr = 1'b0;
    wait_stb(t1);
    chk("arb_busy_after_dma", busy, 1);
    n = 0;
    while (busy && n < 200) begin tick(); n++; end
    chk("arb_cpu_done_gap", n, 18);
    repeat (3) tick();

    // Reset in the middle of a byte.
    exp_q.push_back('{dma: 1'b1, tx: 8'h5A, rx: 8'h99, hp: 1});
    spi_wrdata = 8'h5A; spi_req = 1'b1;
    tick();
    spi_req = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    chk("abort_sck", sck, 0);
    chk("abort_mosi", mosi, 1);
    chk("abort_busy", busy, 0);
    chk("abort_rddata", spi_rddata, 8'hFF);
    chk("abort_stb", spi_stb, 0);
    repeat (20) tick();

    exp_q.push_back('{dma: 1'b1, tx: 8'h0F, rx: 8'hF0, hp: 1});
    spi_wrdata = 8'h0F; spi_req = 1'b1;
    tick();
    spi_req = 1'b0;
    wait_stb(t1);
    chk("post_reset_rddata", spi_rddata, 8'hF0);
    repeat (4) tick();

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
